// File: rtl/axis_rr_arb.sv
// Packet-atomic round-robin merge of two 64-bit AXIS sources onto one master.
// One IDLE arbitration cycle per packet, then a combinational pass-through until the tlast handshake.
module axis_rr_arb #(
  parameter int CNT_WIDTH = 16,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s0_axis_rx_tvalid,
  output logic                 s0_axis_rx_tready,
  input  logic [63:0]          s0_axis_rx_tdata,
  input  logic [7:0]           s0_axis_rx_tkeep,
  input  logic                 s0_axis_rx_tlast,
  input  logic                 s0_axis_rx_tuser,
  input  logic                 s1_axis_rx_tvalid,
  output logic                 s1_axis_rx_tready,
  input  logic [63:0]          s1_axis_rx_tdata,
  input  logic [7:0]           s1_axis_rx_tkeep,
  input  logic                 s1_axis_rx_tlast,
  input  logic                 s1_axis_rx_tuser,
  input  logic                 m_axis_tx_tready,
  output logic                 m_axis_tx_tvalid,
  output logic [63:0]          m_axis_tx_tdata,
  output logic [7:0]           m_axis_tx_tkeep,
  output logic                 m_axis_tx_tlast,
  output logic                 m_axis_tx_tuser,
  output logic                 grant,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pkt_cnt0,
  output logic [CNT_WIDTH-1:0] pkt_cnt1
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic                 r_grant;
  logic                 r_prio;
  logic [CNT_WIDTH-1:0] r_cnt0;
  logic [CNT_WIDTH-1:0] r_cnt1;

  logic w_busy;
  logic w_eop;

  assign w_busy = (r_state == BUSY);

  // The mux follows r_grant in every state; only valid/ready are gated by BUSY.
  assign m_axis_tx_tvalid = w_busy & (r_grant ? s1_axis_rx_tvalid : s0_axis_rx_tvalid);
  assign m_axis_tx_tdata  = r_grant ? s1_axis_rx_tdata : s0_axis_rx_tdata;
  assign m_axis_tx_tkeep  = r_grant ? s1_axis_rx_tkeep : s0_axis_rx_tkeep;
  assign m_axis_tx_tlast  = r_grant ? s1_axis_rx_tlast : s0_axis_rx_tlast;
  assign m_axis_tx_tuser  = r_grant ? s1_axis_rx_tuser : s0_axis_rx_tuser;

  assign s0_axis_rx_tready = w_busy & ~r_grant & m_axis_tx_tready;
  assign s1_axis_rx_tready = w_busy &  r_grant & m_axis_tx_tready;

  assign w_eop = m_axis_tx_tvalid & m_axis_tx_tready & m_axis_tx_tlast;

  assign grant    = r_grant;
  assign busy     = w_busy;
  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= INIT_PRIO;
      r_prio  <= INIT_PRIO;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s0_axis_rx_tvalid | s1_axis_rx_tvalid) begin
            r_grant <= (s0_axis_rx_tvalid & s1_axis_rx_tvalid) ? r_prio : s1_axis_rx_tvalid;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_eop) begin
            r_state <= IDLE;
            r_prio  <= ~r_grant;
            if (r_grant) r_cnt1 <= r_cnt1 + CNT_ONE;
            else         r_cnt0 <= r_cnt0 + CNT_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
